// File: rtl/bram_burst_reader.sv
// Burst reader for a 4-word-wide BRAM: fetches base/len in 4-word groups and streams words out.
// Optional macro BRAM_BURST_PREFETCH_EN adds a spare group buffer for bubble-free streaming.
module bram_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDRW-1:0]     base_addr,
    input  logic [ADDRW:0]       len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDRW-1:0]     addr_read,
    input  logic [4*WIDTH-1:0]   mem_data,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SpanW = ADDRW + 2;

    typedef enum logic [2:0] {StIdle, StAddr, StLoad, StStream, StFin} state_e;

    state_e               state_q, state_d;
    logic [ADDRW-1:0]     addr_read_q, addr_read_d;
    logic [ADDRW-1:0]     grp_addr_q, grp_addr_d;
    logic [ADDRW:0]       rem_q, rem_d;
    logic [1:0]           lane_q, lane_d;
    logic [4*WIDTH-1:0]   cur_buf_q, cur_buf_d;
    logic                 err_q, err_d;

    logic [SpanW-1:0]     span;
    logic                 range_bad;
    logic                 last_lane;
    logic [ADDRW-1:0]     next_grp;

    assign span      = SpanW'(base_addr) + SpanW'(len);
    assign range_bad = span > SpanW'(DEPTH);
    assign next_grp  = grp_addr_q + ADDRW'(4);
    // Final word of a group: lane 3, or the burst's last word in a partial tail.
    assign last_lane = (lane_q == 2'd3) || (rem_q == (ADDRW+1)'(1));

`ifdef BRAM_BURST_PREFETCH_EN
    logic [4*WIDTH-1:0]   nxt_buf_q, nxt_buf_d;
    logic                 nxt_valid_q, nxt_valid_d;
    logic                 pf_addr_q, pf_addr_d;
    logic                 pf_data_q, pf_data_d;
    logic [2:0]           grp_left;
    logic                 more_groups;

    // Another group follows the current one when remaining exceeds the words left in this group.
    assign grp_left    = 3'd4 - {1'b0, lane_q};
    assign more_groups = rem_q > (ADDRW+1)'(grp_left);
`endif

    always_comb begin
        state_d     = state_q;
        addr_read_d = addr_read_q;
        grp_addr_d  = grp_addr_q;
        rem_d       = rem_q;
        lane_d      = lane_q;
        cur_buf_d   = cur_buf_q;
        err_d       = 1'b0;
`ifdef BRAM_BURST_PREFETCH_EN
        nxt_buf_d   = nxt_buf_q;
        nxt_valid_d = nxt_valid_q;
        pf_addr_d   = 1'b0;
        pf_data_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (start) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d     = StAddr;
                        grp_addr_d  = base_addr;
                        addr_read_d = base_addr;
                        rem_d       = len;
                        lane_d      = '0;
`ifdef BRAM_BURST_PREFETCH_EN
                        nxt_valid_d = 1'b0;
`endif
                    end
                end
            end
            StAddr: begin
                state_d = StLoad;
            end
            StLoad: begin
                cur_buf_d = mem_data;
                lane_d    = '0;
                state_d   = StStream;
            end
            StStream: begin
`ifdef BRAM_BURST_PREFETCH_EN
                // Two-stage prefetch: address goes out, data is captured the cycle after.
                pf_data_d = pf_addr_q;
                if (pf_data_q) begin
                    nxt_buf_d   = mem_data;
                    nxt_valid_d = 1'b1;
                end
                if (!nxt_valid_q && !pf_addr_q && !pf_data_q && more_groups) begin
                    addr_read_d = next_grp;
                    pf_addr_d   = 1'b1;
                end
`endif
                if (out_ready) begin
                    rem_d  = rem_q - (ADDRW+1)'(1);
                    lane_d = lane_q + 2'd1;
                    if (last_lane) begin
                        lane_d = '0;
                        if (rem_q == (ADDRW+1)'(1)) begin
                            state_d = StFin;
`ifdef BRAM_BURST_PREFETCH_EN
                        end else if (nxt_valid_q) begin
                            cur_buf_d   = nxt_buf_q;
                            nxt_valid_d = 1'b0;
                            grp_addr_d  = next_grp;
`endif
                        end else begin
                            grp_addr_d  = next_grp;
                            addr_read_d = next_grp;
                            state_d     = StAddr;
`ifdef BRAM_BURST_PREFETCH_EN
                            pf_addr_d   = 1'b0;
                            pf_data_d   = 1'b0;
                            nxt_valid_d = 1'b0;
`endif
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_read_q <= '0;
            grp_addr_q  <= '0;
            rem_q       <= '0;
            lane_q      <= '0;
            cur_buf_q   <= '0;
            err_q       <= 1'b0;
`ifdef BRAM_BURST_PREFETCH_EN
            nxt_buf_q   <= '0;
            nxt_valid_q <= 1'b0;
            pf_addr_q   <= 1'b0;
            pf_data_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_read_q <= addr_read_d;
            grp_addr_q  <= grp_addr_d;
            rem_q       <= rem_d;
            lane_q      <= lane_d;
            cur_buf_q   <= cur_buf_d;
            err_q       <= err_d;
`ifdef BRAM_BURST_PREFETCH_EN
            nxt_buf_q   <= nxt_buf_d;
            nxt_valid_q <= nxt_valid_d;
            pf_addr_q   <= pf_addr_d;
            pf_data_q   <= pf_data_d;
`endif
        end
    end

    assign busy      = (state_q == StAddr) || (state_q == StLoad) || (state_q == StStream);
    assign done      = (state_q == StFin);
    assign err       = err_q;
    assign addr_read = addr_read_q;
    assign out_valid = (state_q == StStream);
    assign out_data  = cur_buf_q[lane_q*WIDTH +: WIDTH];

endmodule

// File: tb/tb_bram_burst_reader.sv
// Scoreboard bench for bram_burst_reader: BRAM model, queue of expected words, timing checks.
module tb_bram_burst_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int ADDRW = 8;
`ifdef BRAM_BURST_PREFETCH_EN
    localparam int Prefetch = 1;
`else
    localparam int Prefetch = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [ADDRW-1:0]   base_addr;
    logic [ADDRW:0]     len;
    logic               busy;
    logic               done;
    logic               err;
    logic [ADDRW-1:0]   addr_read;
    logic [4*WIDTH-1:0] mem_data = '0;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;

    always #5 clk = ~clk;

    bram_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .addr_read (addr_read),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // BRAM model: one-cycle read latency, four consecutive words per read (address wraps).
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            mem_data[k*WIDTH +: WIDTH] <= mem[(int'(addr_read) + k) % DEPTH];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [WIDTH-1:0] exp_q[$];
    int               hs_cyc[$];
    int               first_valid_cyc = -1;
    int               done_cyc = -1;
    int               err_cyc = -1;
    int               n_done = 0;
    int               n_err = 0;
    bit               busy_seen = 1'b0;
    bit               stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    int               ready_mode = 0;

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (busy) busy_seen = 1'b1;
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_ready) begin
                    hs_cyc.push_back(cyc);
                    chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) chk("word_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_not_busy", 32'(busy), 32'd0);
                chk("done_drained", 32'(exp_q.size()), 32'd0);
            end
            if (err) begin
                n_err++;
                err_cyc = cyc;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic run_burst(input int b, input int l, input bit noise);
        int               t0;
        int               n_done0;
        int               n_err0;
        int               budget;
        int               ngroups;
        int               exp_span;
        logic [ADDRW-1:0] addr_before;
        bit               legal;
        legal           = (b + l <= DEPTH);
        first_valid_cyc = -1;
        hs_cyc.delete();
        busy_seen       = 1'b0;
        n_done0         = n_done;
        n_err0          = n_err;
        @(posedge clk);
        #1;
        addr_before = addr_read;
        if (legal) for (int i = 0; i < l; i++) exp_q.push_back(mem[b + i]);
        t0        = cyc;
        start     = 1'b1;
        base_addr = ADDRW'(b);
        len       = (ADDRW+1)'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!legal) begin
            repeat (4) @(negedge clk);
            chk("err_count", 32'(n_err - n_err0), 32'd1);
            chk("err_cycle", 32'(err_cyc), 32'(t0 + 1));
            chk("err_no_busy", 32'(busy_seen), 32'd0);
            chk("err_addr_hold", 32'(addr_read), 32'(addr_before));
            chk("err_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
        end else if (l == 0) begin
            repeat (4) @(negedge clk);
            chk("zero_done_count", 32'(n_done - n_done0), 32'd1);
            chk("zero_done_cycle", 32'(done_cyc), 32'(t0 + 1));
            chk("zero_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
            chk("zero_no_busy", 32'(busy_seen), 32'd0);
        end else begin
            chk("addr_issue", 32'(addr_read), 32'(b));
            budget = 8 * l + 64;
            while (n_done == n_done0 && budget > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                if (noise && busy && $urandom_range(0, 7) == 0) begin
                    start     = 1'b1;
                    base_addr = ADDRW'($urandom);
                    len       = (ADDRW+1)'($urandom_range(0, DEPTH));
                end
                budget--;
            end
            start = 1'b0;
            chk("done_seen", 32'(n_done - n_done0), 32'd1);
            chk("no_err", 32'(n_err - n_err0), 32'd0);
            chk("first_valid", 32'(first_valid_cyc), 32'(t0 + 3));
            chk("word_count", 32'(hs_cyc.size()), 32'(l));
            if (hs_cyc.size() > 0) chk("done_after_last", 32'(done_cyc), 32'(hs_cyc[$] + 1));
            if (ready_mode == 0 && hs_cyc.size() == l) begin
                ngroups  = (l + 3) / 4;
                exp_span = (l - 1) + (Prefetch != 0 ? 0 : 2 * (ngroups - 1));
                chk("stream_span", 32'(hs_cyc[$] - hs_cyc[0]), 32'(exp_span));
            end
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int b;
        int l;
        int r;
        int budget;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_addr", 32'(addr_read), 32'd0);

        ready_mode = 0;
        run_burst(0, 8, 1'b0);
        if (hs_cyc.size() >= 5) begin
            chk("in_group_span", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);
            chk("group_gap", 32'(hs_cyc[4] - hs_cyc[3]), 32'(Prefetch != 0 ? 1 : 3));
        end
        run_burst(5, 3, 1'b0);
        ready_mode = 1;
        run_burst(0, 6, 1'b0);
        ready_mode = 0;
        run_burst(9, 0, 1'b0);
        run_burst(250, 7, 1'b0);
        run_burst(252, 4, 1'b0);
        run_burst(253, 3, 1'b0);

        // Reset in the middle of a long burst, then a fresh burst.
        first_valid_cyc = -1;
        hs_cyc.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) exp_q.push_back(mem[i]);
        start     = 1'b1;
        base_addr = '0;
        len       = (ADDRW+1)'(16);
        @(posedge clk);
        #1;
        start  = 1'b0;
        budget = 20;
        while (hs_cyc.size() < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("pre_reset_handshakes", 32'(hs_cyc.size()), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_addr", 32'(addr_read), 32'd0);
        exp_q.delete();
        run_burst(8, 2, 1'b0);

        // Randomized bursts over random memory contents.
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
        for (int it = 0; it < 40; it++) begin
            ready_mode = $urandom_range(0, 2);
            b = $urandom_range(0, DEPTH - 1);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                l = 0;
            end else if (r == 1) begin
                l = (b > 0) ? (DEPTH - b + 1 + $urandom_range(0, b - 1)) : 1;
            end else if (r == 2) begin
                l = DEPTH - b;
            end else begin
                l = $urandom_range(1, 40);
                if (l > DEPTH - b) l = DEPTH - b;
            end
            run_burst(b, l, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
